mole_hit_scorer: RTL



---
 rtl/mole_hit_scorer_pkg.sv | 17 +
 rtl/mole_hit_scorer_if.sv | 26 ++
 rtl/mole_hit_scorer_button_edge_sync.sv | 28 ++
 rtl/mole_hit_scorer.sv | 131 +++++++++++++
 4 files changed

// File: rtl/mole_hit_scorer_pkg.sv
// rtl/mole_hit_scorer_pkg.sv - shared state encoding and sizing constants for the mole scorer
package mole_hit_scorer_pkg;

    localparam int NUM_HOLES_DEF    = 9;
    localparam int SCORE_DIGITS_DEF = 3;
    localparam int MAX_MISSES_DEF   = 3;
    localparam int DIGIT_W          = 4;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_DARK = 3'd1,
        ST_LIT  = 3'd2,
        ST_DONE = 3'd3,
        ST_OVER = 3'd4
    } state_t;

endpackage

// File: rtl/mole_hit_scorer_if.sv
// rtl/mole_hit_scorer_if.sv - game inputs and score/status outputs of the mole scorer
interface mole_hit_scorer_if
    import mole_hit_scorer_pkg::*;
#(
    parameter int NUM_HOLES    = NUM_HOLES_DEF,
    parameter int SCORE_DIGITS = SCORE_DIGITS_DEF
);
    logic                              start;
    logic [NUM_HOLES-1:0]              lights;
    logic [NUM_HOLES-1:0]              buttons;
    logic                              hit;
    logic                              miss;
    logic [DIGIT_W*SCORE_DIGITS-1:0]   score;
    logic [2:0]                        misses;
    logic                              game_over;

    modport master (
        output start, lights, buttons,
        input  hit, miss, score, misses, game_over
    );

    modport slave (
        input  start, lights, buttons,
        output hit, miss, score, misses, game_over
    );
endinterface

// File: rtl/mole_hit_scorer_button_edge_sync.sv
// rtl/mole_hit_scorer_button_edge_sync.sv - synchronises async buttons and emits one press per rising edge
module button_edge_sync #(
    parameter int WIDTH = 9
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] press
);
    logic [WIDTH-1:0] sync1;
    logic [WIDTH-1:0] sync2;
    logic [WIDTH-1:0] prev;

    // two-flop synchroniser, previous-value flop and a registered rising-edge pulse
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1 <= '0;
            sync2 <= '0;
            prev  <= '0;
            press <= '0;
        end else begin
            sync1 <= din;
            sync2 <= sync1;
            prev  <= sync2;
            press <= sync2 & ~prev;
        end
    end
endmodule

// File: rtl/mole_hit_scorer.sv
// rtl/mole_hit_scorer.sv - decides hit/miss per light flick, keeps BCD score, miss count and game over
module mole_hit_scorer
    import mole_hit_scorer_pkg::*;
#(
    parameter int NUM_HOLES    = NUM_HOLES_DEF,
    parameter int SCORE_DIGITS = SCORE_DIGITS_DEF,
    parameter int MAX_MISSES   = MAX_MISSES_DEF
) (
    input  logic              clk,
    input  logic              reset,
    mole_hit_scorer_if.slave  bus
);
    localparam int         SW         = DIGIT_W * SCORE_DIGITS;
    localparam logic [2:0] MISS_LIMIT = 3'(MAX_MISSES);

    state_t               state, state_n;
    logic [SW-1:0]        score_q, score_n, score_inc;
    logic [2:0]           misses_q, misses_n;
    logic                 hit_q, hit_n;
    logic                 miss_q, miss_n;
    logic [NUM_HOLES-1:0] press;
    logic                 any_press;
    logic                 match;
    logic                 lit_any;

    button_edge_sync #(.WIDTH(NUM_HOLES)) u_sync (
        .clk   (clk),
        .reset (reset),
        .din   (bus.buttons),
        .press (press)
    );

    assign any_press = |press;
    assign match     = |(press & bus.lights);
    assign lit_any   = |bus.lights;

    // BCD ripple increment, frozen once every digit reads 9
    always_comb begin
        logic       carry;
        logic       at_max;
        logic [3:0] digit;
        score_inc = score_q;
        carry     = 1'b1;
        at_max    = 1'b1;
        digit     = '0;
        for (int d = 0; d < SCORE_DIGITS; d++) begin
            digit = score_q[d*DIGIT_W +: DIGIT_W];
            if (digit != 4'd9) at_max = 1'b0;
            if (carry) begin
                if (digit == 4'd9) begin
                    score_inc[d*DIGIT_W +: DIGIT_W] = 4'd0;
                end else begin
                    score_inc[d*DIGIT_W +: DIGIT_W] = digit + 4'd1;
                    carry = 1'b0;
                end
            end
        end
        if (at_max) score_inc = score_q;
    end

    // next state, score, miss count and hit/miss pulses
    always_comb begin
        state_n  = state;
        score_n  = score_q;
        misses_n = misses_q;
        hit_n    = 1'b0;
        miss_n   = 1'b0;
        if (state != ST_IDLE && !bus.start) begin
            state_n = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (bus.start) begin
                        score_n  = '0;
                        misses_n = '0;
                        state_n  = ST_DARK;
                    end
                end
                ST_DARK: begin
                    if (any_press) miss_n = 1'b1;
                    if (lit_any) state_n = ST_LIT;
                end
                ST_LIT: begin
                    if (match) begin
                        hit_n   = 1'b1;
                        score_n = score_inc;
                        state_n = ST_DONE;
                    end else if (!lit_any) begin
                        miss_n  = 1'b1;
                        state_n = ST_DARK;
                    end else if (any_press) begin
                        miss_n = 1'b1;
                    end
                end
                ST_DONE: begin
                    if (!lit_any) state_n = ST_DARK;
                end
                default: begin
                end
            endcase
        end
        // a miss that spends the budget ends the game on the same edge
        if (miss_n) begin
            misses_n = misses_q + 3'd1;
            if (misses_n >= MISS_LIMIT) state_n = ST_OVER;
        end
    end

    // state and output registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= ST_IDLE;
            score_q  <= '0;
            misses_q <= '0;
            hit_q    <= 1'b0;
            miss_q   <= 1'b0;
        end else begin
            state    <= state_n;
            score_q  <= score_n;
            misses_q <= misses_n;
            hit_q    <= hit_n;
            miss_q   <= miss_n;
        end
    end

    assign bus.hit       = hit_q;
    assign bus.miss      = miss_q;
    assign bus.score     = score_q;
    assign bus.misses    = misses_q;
    assign bus.game_over = (state == ST_OVER);
endmodule
